// File: rtl/db_arbiter.sv
// Two-master memory-bus arbiter: grant lands 1 cycle after request, owner held until s_ready/timeout/drop.
// No preemption; the loser waits in its request. Round-robin tie-break when DB_ARB_ROUND_ROBIN_EN is defined, else m0 priority.
`ifndef MEM_ACCESS
`define MEM_ACCESS [1:0]
`endif
`ifndef MEM_ACCESS_NONE
`define MEM_ACCESS_NONE 2'b00
`endif
`ifndef MEM_LEN
`define MEM_LEN [1:0]
`endif

module db_arbiter #(
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             res,
  input  logic `MEM_ACCESS m0_accessType,
  input  logic `MEM_LEN    m0_memLen,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_dataOut,
  input  logic             m0_io,
  output logic             m0_ready,
  output logic [31:0]      m0_dataIn,
  input  logic `MEM_ACCESS m1_accessType,
  input  logic `MEM_LEN    m1_memLen,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_dataOut,
  input  logic             m1_io,
  output logic             m1_ready,
  output logic [31:0]      m1_dataIn,
  output logic `MEM_ACCESS s_accessType,
  output logic `MEM_LEN    s_memLen,
  output logic [31:0]      s_addr,
  output logic [31:0]      s_dataOut,
  output logic             s_io,
  input  logic             s_ready,
  input  logic [31:0]      s_dataIn,
  output logic [1:0]       grant,
  output logic             bus_err
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [15:0] wait_cnt, wait_cnt_nxt;
  logic        req0, req1, own_req, done, timeout, win1;

  assign req0 = (m0_accessType != `MEM_ACCESS_NONE);
  assign req1 = (m1_accessType != `MEM_ACCESS_NONE);

`ifdef DB_ARB_ROUND_ROBIN_EN
  logic last1;

  // On a tie, m1 wins only if m0 took the previous grant.
  assign win1 = req1 && (!req0 || !last1);

  always_ff @(posedge clk or negedge res) begin
    if (!res)
      last1 <= 1'b1;
    else if (state == IDLE && (req0 || req1))
      last1 <= win1;
  end
`else
  assign win1 = req1 && !req0;
`endif

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state    <= IDLE;
      wait_cnt <= 16'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  always_comb begin
    own_req      = 1'b0;
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      OWN0:    own_req = req0;
      OWN1:    own_req = req1;
      default: own_req = 1'b0;
    endcase
    done    = own_req && s_ready;
    timeout = own_req && !s_ready && (wait_cnt == WAIT_LAST);

    case (state)
      IDLE: begin
        if (req0 || req1) begin
          state_nxt    = win1 ? OWN1 : OWN0;
          wait_cnt_nxt = 16'd0;
        end
      end
      OWN0, OWN1: begin
        // A dropped request is a master protocol error: release silently.
        if (!own_req || done || timeout)
          state_nxt = IDLE;
        else
          wait_cnt_nxt = wait_cnt + 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant        = 2'b00;
    s_accessType = `MEM_ACCESS_NONE;
    s_memLen     = '0;
    s_addr       = 32'h0;
    s_dataOut    = 32'h0;
    s_io         = 1'b0;
    case (state)
      OWN0: begin
        grant        = 2'b01;
        s_accessType = m0_accessType;
        s_memLen     = m0_memLen;
        s_addr       = m0_addr;
        s_dataOut    = m0_dataOut;
        s_io         = m0_io;
      end
      OWN1: begin
        grant        = 2'b10;
        s_accessType = m1_accessType;
        s_memLen     = m1_memLen;
        s_addr       = m1_addr;
        s_dataOut    = m1_dataOut;
        s_io         = m1_io;
      end
      default: ;
    endcase
  end

  // On timeout the owner is released with ready and zero data.
  assign bus_err   = timeout;
  assign m0_ready  = grant[0] && (done || timeout);
  assign m1_ready  = grant[1] && (done || timeout);
  assign m0_dataIn = (grant[0] && timeout) ? 32'h0 : s_dataIn;
  assign m1_dataIn = (grant[1] && timeout) ? 32'h0 : s_dataIn;

endmodule

// File: tb/tb_db_arbiter.sv
// Self-checking bench for db_arbiter (TIMEOUT=4): directed scenarios plus a randomized run against a transaction model.
// Honors DB_ARB_ROUND_ROBIN_EN for the expected tie-break.
module tb_db_arbiter;
  localparam int TO = 4;
`ifdef DB_ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        res;
  logic [1:0]  m0_accessType, m1_accessType, m0_memLen, m1_memLen;
  logic [31:0] m0_addr, m1_addr, m0_dataOut, m1_dataOut;
  logic        m0_io, m1_io;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_dataIn, m1_dataIn;
  logic [1:0]  s_accessType, s_memLen;
  logic [31:0] s_addr, s_dataOut, s_dataIn;
  logic        s_io, s_ready;
  logic [1:0]  grant;
  logic        bus_err;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  db_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .res(res),
    .m0_accessType(m0_accessType), .m0_memLen(m0_memLen), .m0_addr(m0_addr),
    .m0_dataOut(m0_dataOut), .m0_io(m0_io), .m0_ready(m0_ready), .m0_dataIn(m0_dataIn),
    .m1_accessType(m1_accessType), .m1_memLen(m1_memLen), .m1_addr(m1_addr),
    .m1_dataOut(m1_dataOut), .m1_io(m1_io), .m1_ready(m1_ready), .m1_dataIn(m1_dataIn),
    .s_accessType(s_accessType), .s_memLen(s_memLen), .s_addr(s_addr),
    .s_dataOut(s_dataOut), .s_io(s_io), .s_ready(s_ready), .s_dataIn(s_dataIn),
    .grant(grant), .bus_err(bus_err)
  );

  task automatic clear_inputs();
    m0_accessType = 2'b00; m0_memLen = 2'b00; m0_addr = 32'h0; m0_dataOut = 32'h0; m0_io = 1'b0;
    m1_accessType = 2'b00; m1_memLen = 2'b00; m1_addr = 32'h0; m1_dataOut = 32'h0; m1_io = 1'b0;
    s_ready = 1'b0; s_dataIn = 32'h0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at posedge+1 of the first edge after res rises, DUT idle.
  task automatic do_reset();
    res = 1'b0;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    res = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    clear_inputs();
    res = 1'b0;
    m0_accessType = 2'b01; m1_accessType = 2'b01; s_ready = 1'b1; m0_addr = 32'h55;
    #3;
    checks++; if (grant !== 2'b00) begin errs++; $display("FAIL reset_grant got=%b exp=00", grant); end
    checks++; if (bus_err !== 1'b0) begin errs++; $display("FAIL reset_bus_err got=%b exp=0", bus_err); end
    checks++; if ({m0_ready, m1_ready} !== 2'b00) begin errs++; $display("FAIL reset_ready got=%b exp=00", {m0_ready, m1_ready}); end
    checks++; if ({s_accessType, s_addr} !== 34'h0) begin errs++; $display("FAIL reset_s_bus got=%h exp=0", {s_accessType, s_addr}); end
    next_cycle();
    checks++; if (grant !== 2'b00) begin errs++; $display("FAIL reset_hold_grant got=%b exp=00", grant); end
  endtask

  task automatic test_single_read();
    do_reset();
    m0_accessType = 2'b01; m0_memLen = 2'b10; m0_addr = 32'h100;
    s_ready = 1'b1; s_dataIn = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if ({grant, m0_ready} !== 3'b000) begin errs++; $display("FAIL read_idle got=%b exp=000", {grant, m0_ready}); end
    next_cycle(); @(negedge clk);
    checks++; if (grant !== 2'b01) begin errs++; $display("FAIL read_grant got=%b exp=01", grant); end
    checks++; if ({m0_ready, m1_ready} !== 2'b10) begin errs++; $display("FAIL read_ready got=%b exp=10", {m0_ready, m1_ready}); end
    checks++; if (m0_dataIn !== 32'hDEADBEEF) begin errs++; $display("FAIL read_data got=%h exp=deadbeef", m0_dataIn); end
    checks++; if (s_addr !== 32'h100) begin errs++; $display("FAIL read_addr got=%h exp=100", s_addr); end
    next_cycle();
    m0_accessType = 2'b00;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errs++; $display("FAIL read_back_idle got=%b exp=00", grant); end
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp;
    do_reset();
    m0_accessType = 2'b01; m1_accessType = 2'b01; s_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i % 2 == 0) exp = 2'b00;
      else if (RR && ((i - 1) / 2) % 2 == 1) exp = 2'b10;
      else exp = 2'b01;
      checks++; if (grant !== exp) begin errs++; $display("FAIL b2b_grant[%0d] got=%b exp=%b", i, grant, exp); end
      next_cycle();
    end
  endtask

  task automatic test_no_preempt();
    do_reset();
    m1_accessType = 2'b01; m1_addr = 32'hA0;
    @(negedge clk);
    next_cycle();
    m0_accessType = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if ({grant, m0_ready, m1_ready} !== 4'b1000) begin errs++; $display("FAIL hold_own1[%0d] got=%b exp=1000", i, {grant, m0_ready, m1_ready}); end
      next_cycle();
    end
    s_ready = 1'b1;
    @(negedge clk);
    checks++; if ({grant, m0_ready, m1_ready} !== 4'b1001) begin errs++; $display("FAIL hold_done got=%b exp=1001", {grant, m0_ready, m1_ready}); end
    next_cycle();
    m1_accessType = 2'b00; s_ready = 1'b0;
    @(negedge clk);
    checks++; if (grant !== 2'b00) begin errs++; $display("FAIL hold_gap got=%b exp=00", grant); end
    next_cycle(); @(negedge clk);
    checks++; if (grant !== 2'b01) begin errs++; $display("FAIL hold_m0_next got=%b exp=01", grant); end
  endtask

  task automatic test_timeout();
    do_reset();
    m0_accessType = 2'b01; s_dataIn = 32'h12345678;
    @(negedge clk);
    next_cycle();
    for (int i = 1; i <= TO; i++) begin
      @(negedge clk);
      if (i < TO) begin
        checks++; if ({grant, bus_err, m0_ready} !== 4'b0100) begin errs++; $display("FAIL tmo_wait[%0d] got=%b exp=0100", i, {grant, bus_err, m0_ready}); end
      end else begin
        checks++; if ({grant, bus_err, m0_ready, m1_ready} !== 5'b01110) begin errs++; $display("FAIL tmo_pulse got=%b exp=01110", {grant, bus_err, m0_ready, m1_ready}); end
        checks++; if (m0_dataIn !== 32'h0) begin errs++; $display("FAIL tmo_data got=%h exp=0", m0_dataIn); end
        checks++; if (m1_dataIn !== 32'h12345678) begin errs++; $display("FAIL tmo_bcast got=%h exp=12345678", m1_dataIn); end
      end
      next_cycle();
    end
    m0_accessType = 2'b00;
    @(negedge clk);
    checks++; if ({grant, bus_err} !== 3'b000) begin errs++; $display("FAIL tmo_idle got=%b exp=000", {grant, bus_err}); end
  endtask

  task automatic test_reset_mid();
    logic [1:0] exp;
    do_reset();
    m0_accessType = 2'b01; m1_accessType = 2'b01;
    @(negedge clk);
    next_cycle(); @(negedge clk);
    checks++; if (grant !== 2'b01) begin errs++; $display("FAIL rmid_own0 got=%b exp=01", grant); end
    #2 res = 1'b0;
    #1;
    checks++; if ({grant, s_accessType, bus_err, m0_ready, m1_ready} !== 7'b0) begin errs++; $display("FAIL rmid_abort got=%b exp=0000000", {grant, s_accessType, bus_err, m0_ready, m1_ready}); end
    @(negedge clk);
    res = 1'b1;
    next_cycle();
    s_ready = 1'b1;
    @(negedge clk);
    checks++; if ({grant, m0_ready} !== 3'b011) begin errs++; $display("FAIL rmid_first got=%b exp=011", {grant, m0_ready}); end
    next_cycle(); @(negedge clk);
    next_cycle(); @(negedge clk);
    exp = RR ? 2'b10 : 2'b01;
    checks++; if (grant !== exp) begin errs++; $display("FAIL rmid_tie got=%b exp=%b", grant, exp); end
  endtask

  task automatic test_io_write();
    logic [31:0] d;
    do_reset();
    d = $urandom;
    m0_accessType = 2'b10; m0_memLen = 2'b10; m0_io = 1'b1; m0_addr = 32'h0; m0_dataOut = d;
    m1_accessType = 2'b01; m1_memLen = 2'b00; m1_io = 1'b0; m1_addr = 32'hFFFF_FFF0; m1_dataOut = ~d;
    @(negedge clk);
    next_cycle(); @(negedge clk);
    checks++; if ({grant, s_io, s_addr} !== {2'b01, 1'b1, 32'h0}) begin errs++; $display("FAIL io_fwd got=%b/%b/%h exp=01/1/0", grant, s_io, s_addr); end
    checks++; if ({s_accessType, s_memLen, s_dataOut} !== {2'b10, 2'b10, d}) begin errs++; $display("FAIL io_data got=%h exp=%h", {s_accessType, s_memLen, s_dataOut}, {2'b10, 2'b10, d}); end
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_random();
    logic [1:0]  acc [2], len [2];
    logic [31:0] adr [2], dout [2], dexp [2];
    logic        io [2], act [2], rdy [2];
    int          owner, wcnt, last, n;
    logic        err, r0, r1;
    logic [1:0]  g;
    logic [137:0] got, exp;
    do_reset();
    owner = -1; wcnt = 0; last = 1;
    for (int i = 0; i < 2; i++) begin act[i] = 0; acc[i] = 0; len[i] = 0; adr[i] = 0; dout[i] = 0; io[i] = 0; end
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (!act[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            act[i] = 1; acc[i] = 2'($urandom_range(1, 3)); len[i] = 2'($urandom_range(0, 2));
            adr[i] = $urandom; dout[i] = $urandom; io[i] = 1'($urandom_range(0, 1));
          end else acc[i] = 2'b00;
        end else if ($urandom_range(0, 59) == 0) begin
          act[i] = 0; acc[i] = 2'b00;
        end
      end
      m0_accessType = acc[0]; m0_memLen = len[0]; m0_addr = adr[0]; m0_dataOut = dout[0]; m0_io = io[0];
      m1_accessType = acc[1]; m1_memLen = len[1]; m1_addr = adr[1]; m1_dataOut = dout[1]; m1_io = io[1];
      s_ready = ($urandom_range(0, 9) < 3); s_dataIn = $urandom;
      @(negedge clk);
      r0 = (acc[0] != 0); r1 = (acc[1] != 0);
      rdy[0] = 0; rdy[1] = 0; err = 0; dexp[0] = s_dataIn; dexp[1] = s_dataIn;
      if (owner < 0) begin
        g = 2'b00;
        exp = {g, 3'b000, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, dexp[0], dexp[1]};
        if (r0 || r1) begin
          if (r0 && r1) n = (RR && last == 0) ? 1 : 0;
          else n = r1 ? 1 : 0;
          owner = n; last = n; wcnt = 0;
        end
      end else begin
        n = owner;
        g = (n == 0) ? 2'b01 : 2'b10;
        if (acc[n] == 0) owner = -1;
        else if (s_ready) begin rdy[n] = 1; owner = -1; end
        else if (wcnt == TO - 1) begin err = 1; rdy[n] = 1; dexp[n] = 32'h0; owner = -1; end
        else wcnt++;
        exp = {g, err, rdy[0], rdy[1], acc[n], len[n], io[n], adr[n], dout[n], dexp[0], dexp[1]};
      end
      got = {grant, bus_err, m0_ready, m1_ready, s_accessType, s_memLen, s_io, s_addr, s_dataOut, m0_dataIn, m1_dataIn};
      checks++; if (got !== exp) begin errs++; $display("FAIL random[%0d] got=%h exp=%h", cyc, got, exp); end
      for (int i = 0; i < 2; i++) if (rdy[i]) act[i] = 0;
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    res = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_no_preempt();
    test_timeout();
    test_reset_mid();
    test_io_write();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/db_arbiter.md
DB_ARBITER -- requirements
Module: db_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, meaning the maximum cycles a granted transfer waits for s_ready before abort (1..65535).
REQ-002 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-003 SHALL have: res  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have: m0_accessType  in  `MEM_ACCESS  master 0 (CPU_MMU) request; `MEM_ACCESS_NONE means idle.
REQ-005 SHALL have: m0_memLen  in  `MEM_LEN  transfer size; m0_addr  in  32  physical address; m0_dataOut  in  32  write data; m0_io  in  1  I/O space select.
REQ-006 SHALL have: m0_ready  out  1  transfer done; m0_dataIn  out  32  read data.
REQ-007 SHALL have m1_accessType, m1_memLen, m1_addr, m1_dataOut, m1_io, m1_ready, m1_dataIn: same widths and meanings for master 1 (DMA/debug).
REQ-008 SHALL have: s_accessType  out  `MEM_ACCESS, s_memLen  out  `MEM_LEN, s_addr  out  32, s_dataOut  out  32, s_io  out  1  forwarded to the slave.
REQ-009 SHALL have: s_ready  in  1  slave done; s_dataIn  in  32  slave read data.
REQ-010 SHALL have: grant  out  2  one-hot owner (bit0 = m0, bit1 = m1, 00 = none); bus_err  out  1  one-cycle timeout pulse.

Function
REQ-011 SHALL implement states IDLE, OWN0, OWN1; a request is accessType != `MEM_ACCESS_NONE held stable until that master sees ready.
REQ-012 IDLE: no request -> stay; exactly one requester -> OWNn at next edge; both -> winner per REQ-020/021.
REQ-013 OWNn SHALL forward master n's accessType, memLen, addr, dataOut, io combinationally to s_*; in IDLE s_accessType = `MEM_ACCESS_NONE and s_memLen, s_addr, s_dataOut, s_io = 0.
REQ-014 mn_ready SHALL equal s_ready AND grant[n]; the non-owner's ready SHALL be 0.
REQ-015 s_dataIn SHALL be broadcast to m0_dataIn and m1_dataIn unmodified.
REQ-016 Edge in OWNn with s_ready = 1 SHALL complete the transfer and return to IDLE; arbitration latency = 1 cycle, and one IDLE cycle separates back-to-back grants.
REQ-017 The owner SHALL NOT change in OWNn regardless of the other master's request (no preemption).
REQ-018 A 16-bit wait counter SHALL clear on entry to OWNn and increment each OWNn cycle with s_ready = 0; reaching TIMEOUT SHALL return to IDLE, pulse bus_err for exactly one cycle and force mn_ready = 1 for that same cycle with mn_dataIn = 32'h0.
REQ-019 If the owner drops its request while in OWNn (protocol error), the arbiter SHALL return to IDLE at the next edge without asserting ready.

Reset
REQ-022 res low SHALL immediately force: state IDLE, grant = 00, bus_err = 0, wait counter 0, last-winner = m1 (so m0 wins the first tie), all s_* idle/zero, m0_ready = m1_ready = 0.
REQ-023 Reset asserted mid-transfer SHALL abandon the transfer with no ready or bus_err; first grant is possible at the first edge after res rises.

Configuration
REQ-020 With macro DB_ARB_ROUND_ROBIN_EN defined: on a tie in IDLE, the master that did not win the previous grant SHALL win; the last-winner register updates on every grant.
REQ-021 Without DB_ARB_ROUND_ROBIN_EN: fixed priority, m0 always wins ties, and no last-winner register is present.

Verification
REQ-024 Only m0 reads a word at 0x100 with s_ready = 1 and s_dataIn = 0xDEADBEEF -> grant = 01 one cycle after the request, m0_ready = 1 with m0_dataIn = 0xDEADBEEF, then IDLE.
REQ-025 m0 and m1 request continuously, ROUND_ROBIN_EN defined -> grants 01, 10, 01, 10 with one IDLE cycle between each; without the macro -> 01, 01, 01, and m1 starves.
REQ-026 m1 owns the bus with s_ready held low for 3 cycles while m0 requests -> grant stays 10, m0_ready = 0 throughout, and m0 is granted after m1 completes.
REQ-027 TIMEOUT = 4 and s_ready stuck at 0 -> bus_err pulses exactly one cycle in the 4th OWN cycle, the owner sees ready = 1 with data 0, and the arbiter is then IDLE.
REQ-028 res driven low during OWN0 with s_ready = 0 -> grant = 00 and s_accessType = NONE immediately, no ready or bus_err, and after release m1 wins a tie under round-robin.
REQ-029 m0 io write to address 0 with memLen W -> s_io = 1, s_addr = 0 and s_dataOut = m0_dataOut during OWN0.
